// File: rtl/atm_cash_dispenser_if.sv
`timescale 1ns/1ps
// Withdraw-path handshake between the ATM transaction controller (master)
// and the cash dispenser (slave).
interface atm_cash_dispenser_if;
  logic        req_valid;
  logic [10:0] req_amount;
  logic        req_ready;
  logic        resp_valid;
  logic [1:0]  resp_status;

  modport master (output req_valid, req_amount,
                  input  req_ready, resp_valid, resp_status);
  modport slave  (input  req_valid, req_amount,
                  output req_ready, resp_valid, resp_status);
endinterface

// File: rtl/atm_cash_dispenser.sv
`timescale 1ns/1ps
// Cash-dispenser controller: accepts an approved amount, plans a greedy
// 100/50/20/10 breakdown against four cassettes, ejects one note per slot
// and returns a status response.
// Optional feature macro: DISPENSER_RETRACT_EN (present cash, retract on timeout).
module atm_cash_dispenser #(
  parameter int unsigned NOTE_CYCLES  = 4,
  parameter int unsigned INIT_N100    = 10,
  parameter int unsigned INIT_N50     = 10,
  parameter int unsigned INIT_N20     = 10,
  parameter int unsigned INIT_N10     = 10,
  parameter int unsigned TAKE_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  atm_cash_dispenser_if.slave        bus,
  output logic [3:0]                 eject,
  output logic [7:0]                 cnt_100,
  output logic [7:0]                 cnt_50,
  output logic [7:0]                 cnt_20,
  output logic [7:0]                 cnt_10,
  input  logic                       load_valid,
  input  logic [7:0]                 load_100,
  input  logic [7:0]                 load_50,
  input  logic [7:0]                 load_20,
  input  logic [7:0]                 load_10,
  input  logic                       cash_taken
);

  localparam int unsigned CYC_W = $clog2(NOTE_CYCLES);
  localparam logic [1:0]  ST_OK       = 2'b00;
  localparam logic [1:0]  ST_BAD      = 2'b01;
  localparam logic [1:0]  ST_NO_NOTES = 2'b10;

`ifdef DISPENSER_RETRACT_EN
  localparam int unsigned TMR_W        = 16;
  localparam logic [1:0]  ST_RETRACTED = 2'b11;
  typedef enum logic [2:0] {IDLE, PLAN, CHECK, EJECT, PRESENT, RESP} state_t;
  logic [TMR_W-1:0] tmr_q, tmr_d;
`else
  localparam int unsigned unused_take_timeout = TAKE_TIMEOUT;
  typedef enum logic [2:0] {IDLE, PLAN, CHECK, EJECT, RESP} state_t;
  logic unused_cash_taken;
  assign unused_cash_taken = cash_taken;
`endif

  // Denomination value for plan/cassette index (0=100, 1=50, 2=20, 3=10).
  function automatic logic [10:0] denom(input logic [1:0] idx);
    case (idx)
      2'd0:    denom = 11'd100;
      2'd1:    denom = 11'd50;
      2'd2:    denom = 11'd20;
      default: denom = 11'd10;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [10:0]      rem_q, rem_d;
  logic [1:0]       pidx_q, pidx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0][7:0]  plan_q, plan_d;
  logic [3:0][7:0]  cnt_q, cnt_d;
  logic [3:0]       eject_q, eject_d;
  logic             ready_q, rvalid_q;
  logic [1:0]       status_q, status_d;

  logic [10:0]      dval, quot;
  logic [7:0]       take;
  logic [1:0]       sel;
  logic             has_note, issue;

  // Highest-value denomination still owed by the plan.
  always_comb begin
    sel      = 2'd0;
    has_note = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (plan_q[i] != 8'd0) begin
        sel      = 2'(i);
        has_note = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pidx_d   = pidx_q;
    cyc_d    = cyc_q;
    plan_d   = plan_q;
    cnt_d    = cnt_q;
    eject_d  = 4'b0000;
    status_d = status_q;
    dval     = denom(pidx_q);
    quot     = 11'd0;
    take     = 8'd0;
    issue    = 1'b0;
`ifdef DISPENSER_RETRACT_EN
    tmr_d    = tmr_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_valid) cnt_d = {load_10, load_20, load_50, load_100};
        if (ready_q && bus.req_valid) begin
          if (bus.req_amount == 11'd0 || (bus.req_amount % 11'd10) != 11'd0) begin
            state_d  = RESP;
            status_d = ST_BAD;
          end else begin
            rem_d   = bus.req_amount;
            pidx_d  = 2'd0;
            plan_d  = '0;
            state_d = PLAN;
          end
        end
      end
      PLAN: begin
        quot = rem_q / dval;
        if (quot > {3'b000, cnt_q[pidx_q]}) take = cnt_q[pidx_q];
        else                                take = quot[7:0];
        plan_d[pidx_q] = take;
        rem_d          = rem_q - 11'(take) * dval;
        pidx_d         = pidx_q + 2'd1;
        if (pidx_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        if (rem_q != 11'd0) begin
          state_d  = RESP;
          status_d = ST_NO_NOTES;
          plan_d   = '0;
        end else begin
          issue = 1'b1;
        end
      end
      EJECT: begin
        if (cyc_q == CYC_W'(NOTE_CYCLES - 1)) begin
          if (has_note) begin
            issue = 1'b1;
          end else begin
`ifdef DISPENSER_RETRACT_EN
            state_d = PRESENT;
            tmr_d   = '0;
`else
            state_d  = RESP;
            status_d = ST_OK;
`endif
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
`ifdef DISPENSER_RETRACT_EN
      PRESENT: begin
        if (cash_taken) begin
          state_d  = RESP;
          status_d = ST_OK;
        end else if (tmr_q == TMR_W'(TAKE_TIMEOUT - 1)) begin
          state_d  = RESP;
          status_d = ST_RETRACTED;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Start a note slot: pulse eject and take the note from cassette and plan.
    if (issue) begin
      state_d      = EJECT;
      cyc_d        = '0;
      eject_d      = 4'b1000 >> sel;
      cnt_d[sel]   = cnt_q[sel] - 8'd1;
      plan_d[sel]  = plan_q[sel] - 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      pidx_q   <= '0;
      cyc_q    <= '0;
      plan_q   <= '0;
      cnt_q    <= {8'(INIT_N10), 8'(INIT_N20), 8'(INIT_N50), 8'(INIT_N100)};
      eject_q  <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      status_q <= ST_OK;
`ifdef DISPENSER_RETRACT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      pidx_q   <= pidx_d;
      cyc_q    <= cyc_d;
      plan_q   <= plan_d;
      cnt_q    <= cnt_d;
      eject_q  <= eject_d;
      ready_q  <= (state_d == IDLE);
      rvalid_q <= (state_d == RESP);
      status_q <= status_d;
`ifdef DISPENSER_RETRACT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = rvalid_q;
  assign bus.resp_status = status_q;
  assign eject           = eject_q;
  assign cnt_100         = cnt_q[0];
  assign cnt_50          = cnt_q[1];
  assign cnt_20          = cnt_q[2];
  assign cnt_10          = cnt_q[3];

endmodule
